// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver and its in-flight queue.
// The PC width lives here because the queue entry struct depends on it.
package branch_pkg;

  localparam int ADDR_W      = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [1:0] BR_COND_HOLD  = 2'b00;
  localparam logic [1:0] BR_COND_TRAIN = 2'b01;

  typedef struct packed {
    logic              taken;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
  } bq_entry_t;

  typedef enum logic {
    BR_IDLE,
    BR_FLUSH
  } br_state_t;

endpackage

// File: rtl/branch_queue.sv
// In-order FIFO of predicted branches awaiting resolution.
// A clear empties the queue and wins over a push in the same cycle.
module branch_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn_h,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  bq_entry_t                    din,
  output bq_entry_t                    dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  bq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn_h) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/branch_resolver.sv
// Matches queued branch predictions against EX outcomes in order, trains the
// predictor, and on a mispredict holds flush with the corrected fetch PC.
//
//   state    | meaning
//   BR_IDLE  | accepting pushes, resolving the queue head on res_valid
//   BR_FLUSH | flush + redirect_pc held; pushes and resolutions ignored
module branch_resolver
  import branch_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        rstn_h,
  input  logic                        pred_valid,
  input  logic                        pred_taken_in,
  input  logic [ADDR_W-1:0]           pred_pc,
  input  logic [ADDR_W-1:0]           pred_target,
  output logic                        pred_ready,
  input  logic                        res_valid,
  input  logic                        res_taken,
  output logic [1:0]                  upd_cond,
  output logic                        upd_act_taken,
  output logic                        upd_pred_taken,
  output logic                        flush,
  output logic [ADDR_W-1:0]           redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]            br_cnt,
  output logic [CNT_W-1:0]            mis_cnt,
  output logic                        err_underflow
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  br_state_t         state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;
  logic [1:0]        upd_cond_q, upd_cond_d;
  logic              upd_act_q, upd_act_d;
  logic              upd_pred_q, upd_pred_d;
  logic [CNT_W-1:0]  br_q, br_d;
  logic [CNT_W-1:0]  mis_q, mis_d;
  logic              err_q, err_d;

  bq_entry_t q_din, q_head;
  logic      q_full, q_empty, do_push, do_pop, mispred;

  assign q_din      = '{taken: pred_taken_in, pc: pred_pc, target: pred_target};
  assign pred_ready = !q_full && (state_q == BR_IDLE);
  assign do_push    = pred_valid && pred_ready;
  assign do_pop     = res_valid && (state_q == BR_IDLE) && !q_empty;
  assign mispred    = do_pop && (res_taken != q_head.taken);

  // A mispredict clears the queue, discarding any same-cycle wrong-path push.
  branch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk    (clk),
    .rstn_h (rstn_h),
    .push   (do_push),
    .pop    (do_pop),
    .clear  (mispred),
    .din    (q_din),
    .dout   (q_head),
    .full   (q_full),
    .empty  (q_empty),
    .count  (occupancy)
  );

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    flush_d    = flush_q;
    redirect_d = redirect_q;
    upd_cond_d = BR_COND_HOLD;
    upd_act_d  = 1'b0;
    upd_pred_d = 1'b0;
    br_d       = br_q;
    mis_d      = mis_q;
    err_d      = err_q;
    case (state_q)
      BR_IDLE: begin
        if (res_valid && q_empty) err_d = 1'b1;
        if (do_pop) begin
          upd_cond_d = BR_COND_TRAIN;
          upd_act_d  = res_taken;
          upd_pred_d = q_head.taken;
          br_d       = (&br_q) ? br_q : br_q + 1'b1;
        end
        if (mispred) begin
          mis_d      = (&mis_q) ? mis_q : mis_q + 1'b1;
          state_d    = BR_FLUSH;
          fcnt_d     = FC_W'(FLUSH_CYCLES - 1);
          flush_d    = 1'b1;
          redirect_d = res_taken ? q_head.target : q_head.pc + ADDR_W'(INSTR_BYTES);
        end
      end
      BR_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = BR_IDLE;
          flush_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn_h) begin
      state_q    <= BR_IDLE;
      fcnt_q     <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      upd_cond_q <= BR_COND_HOLD;
      upd_act_q  <= 1'b0;
      upd_pred_q <= 1'b0;
      br_q       <= '0;
      mis_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      upd_cond_q <= upd_cond_d;
      upd_act_q  <= upd_act_d;
      upd_pred_q <= upd_pred_d;
      br_q       <= br_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_pc    = redirect_q;
  assign upd_cond       = upd_cond_q;
  assign upd_act_taken  = upd_act_q;
  assign upd_pred_taken = upd_pred_q;
  assign br_cnt         = br_q;
  assign mis_cnt        = mis_q;
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table, saturation sequence on a
// CNT_W=4 instance, and random traffic against a queue-based reference model.
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int FLUSH_CYCLES = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_h, pred_valid, pred_taken_in, res_valid, res_taken;
  logic [31:0] pred_pc, pred_target;

  logic        pred_ready, upd_act_taken, upd_pred_taken, flush, err_underflow;
  logic [1:0]  upd_cond;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;
  logic [15:0] br_cnt, mis_cnt;

  logic        pred_ready_s, upd_act_s, upd_pred_s, flush_s, err_s;
  logic [1:0]  upd_cond_s;
  logic [31:0] redirect_s;
  logic [2:0]  occupancy_s;
  logic [3:0]  br_cnt_s, mis_cnt_s;

  branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
    .clk(clk), .rstn_h(rstn_h), .pred_valid(pred_valid), .pred_taken_in(pred_taken_in),
    .pred_pc(pred_pc), .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .upd_cond(upd_cond),
    .upd_act_taken(upd_act_taken), .upd_pred_taken(upd_pred_taken), .flush(flush),
    .redirect_pc(redirect_pc), .occupancy(occupancy), .br_cnt(br_cnt),
    .mis_cnt(mis_cnt), .err_underflow(err_underflow)
  );

  branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(4)) dut_sat (
    .clk(clk), .rstn_h(rstn_h), .pred_valid(pred_valid), .pred_taken_in(pred_taken_in),
    .pred_pc(pred_pc), .pred_target(pred_target), .pred_ready(pred_ready_s),
    .res_valid(res_valid), .res_taken(res_taken), .upd_cond(upd_cond_s),
    .upd_act_taken(upd_act_s), .upd_pred_taken(upd_pred_s), .flush(flush_s),
    .redirect_pc(redirect_s), .occupancy(occupancy_s), .br_cnt(br_cnt_s),
    .mis_cnt(mis_cnt_s), .err_underflow(err_s)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference model: an in-order list of outstanding predictions plus a flush timer.
  typedef struct {bit taken; bit [31:0] pc; bit [31:0] tgt;} ent_t;
  ent_t        mq[$];
  int          m_flush_left = 0;
  int          m_br = 0;
  int          m_mis = 0;
  bit          m_err = 0;
  bit   [1:0]  m_cond = 0;
  bit          m_act = 0, m_pred = 0;
  bit   [31:0] m_redir = 0;

  always @(posedge clk) begin
    ent_t h;
    bit   ready, killed;
    m_cond = 0; m_act = 0; m_pred = 0;
    if (rstn_h) begin
      mq.delete();
      m_flush_left = 0; m_br = 0; m_mis = 0; m_err = 0; m_redir = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else begin
      ready  = mq.size() < DEPTH;
      killed = 0;
      if (res_valid && mq.size() == 0) begin
        m_err = 1;
      end else if (res_valid) begin
        h = mq.pop_front();
        m_cond = 2'b01; m_act = res_taken; m_pred = h.taken;
        if (m_br < 65535) m_br++;
        if (h.taken != res_taken) begin
          if (m_mis < 65535) m_mis++;
          m_flush_left = FLUSH_CYCLES;
          m_redir = res_taken ? h.tgt : h.pc + 32'd4;
          mq.delete();
          killed = 1;
        end
      end
      if (pred_valid && ready && !killed) begin
        h.taken = pred_taken_in; h.pc = pred_pc; h.tgt = pred_target;
        mq.push_back(h);
      end
    end
  end

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_check();
    chk("m_cond", upd_cond, m_cond);
    chk("m_act", upd_act_taken, m_act);
    chk("m_pred", upd_pred_taken, m_pred);
    chk("m_flush", flush, m_flush_left > 0);
    if (m_flush_left > 0) chk("m_redir", redirect_pc, m_redir);
    chk("m_occ", occupancy, mq.size());
    chk("m_ready", pred_ready, (m_flush_left == 0) && (mq.size() < DEPTH));
    chk("m_br", br_cnt, m_br);
    chk("m_mis", mis_cnt, m_mis);
    chk("m_err", err_underflow, m_err);
    chk("s_br", br_cnt_s, sat15(m_br));
    chk("s_mis", mis_cnt_s, sat15(m_mis));
    chk("s_occ", occupancy_s, mq.size());
    chk("s_flush", flush_s, m_flush_left > 0);
    chk("s_ready", pred_ready_s, (m_flush_left == 0) && (mq.size() < DEPTH));
    chk("s_upd", {upd_cond_s, upd_act_s, upd_pred_s, err_s}, {m_cond, m_act, m_pred, m_err});
    if (m_flush_left > 0) chk("s_redir", redirect_s, m_redir);
  endtask

  task automatic step(input bit rst, input bit pv, input bit pt, input bit [31:0] pc,
                      input bit [31:0] tgt, input bit rv, input bit rt);
    rstn_h = rst; pred_valid = pv; pred_taken_in = pt; pred_pc = pc; pred_target = tgt;
    res_valid = rv; res_taken = rt;
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    bit rst, pv, pt; bit [31:0] pc, tgt; bit rv, rt;
    bit [1:0] e_cond; bit e_act, e_pred, e_flush; bit [31:0] e_redir;
    int e_occ; bit e_ready, e_err;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(bit rst, bit pv, bit pt, bit [31:0] pc, bit [31:0] tgt, bit rv, bit rt,
                              bit [1:0] c, bit a, bit p, bit f, bit [31:0] rd, int o, bit r, bit e);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pt = pt; v.pc = pc; v.tgt = tgt; v.rv = rv; v.rt = rt;
    v.e_cond = c; v.e_act = a; v.e_pred = p; v.e_flush = f; v.e_redir = rd;
    v.e_occ = o; v.e_ready = r; v.e_err = e;
    return v;
  endfunction

  initial begin
    rstn_h = 1; pred_valid = 0; pred_taken_in = 0; pred_pc = 0; pred_target = 0;
    res_valid = 0; res_taken = 0;

    //          rst pv pt pc      tgt     rv rt  cond a p f redir   occ rdy err
    vt.push_back(mk(1, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 0,      0, 1, 0));
    vt.push_back(mk(0, 1, 1, 'h100,  'h200,  0, 0, 0, 0, 0, 0, 0,      1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,      0,      1, 1, 1, 1, 1, 0, 0,      0, 1, 0));
    vt.push_back(mk(0, 1, 0, 'h100,  'h200,  0, 0, 0, 0, 0, 0, 0,      1, 1, 0));
    vt.push_back(mk(0, 1, 1, 'h110,  'h400,  0, 0, 0, 0, 0, 0, 0,      2, 1, 0));
    vt.push_back(mk(0, 1, 1, 'h120,  'h410,  0, 0, 0, 0, 0, 0, 0,      3, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,      0,      1, 1, 1, 1, 0, 1, 'h200,  0, 0, 0));
    vt.push_back(mk(0, 1, 1, 'h130,  'h420,  1, 0, 0, 0, 0, 1, 'h200,  0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 0,      0, 1, 0));
    vt.push_back(mk(0, 1, 1, 'h300,  'h500,  0, 0, 0, 0, 0, 0, 0,      1, 1, 0));
    vt.push_back(mk(0, 1, 0, 'h310,  'h510,  1, 0, 1, 0, 1, 1, 'h304,  0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 1, 'h304,  0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 0,      0, 1, 0));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(0, 1, 1, 'h400 + 32'(i * 16), 'h600, 0, 0, 0, 0, 0, 0, 0, i + 1, i < 3, 0));
    vt.push_back(mk(0, 1, 1, 'h440,  'h640,  0, 0, 0, 0, 0, 0, 0,      4, 0, 0));
    vt.push_back(mk(0, 1, 1, 'h450,  'h650,  1, 1, 1, 1, 1, 0, 0,      3, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,      0,      1, 1, 1, 1, 1, 0, 0,      2, 1, 0));
    vt.push_back(mk(0, 1, 1, 'h460,  'h660,  1, 1, 1, 1, 1, 0, 0,      2, 1, 0));
    vt.push_back(mk(0, 1, 1, 'h470,  'h670,  1, 1, 1, 1, 1, 0, 0,      2, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,      0,      1, 1, 1, 1, 1, 0, 0,      1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,      0,      1, 1, 1, 1, 1, 0, 0,      0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,      0,      1, 1, 0, 0, 0, 0, 0,      0, 1, 1));
    vt.push_back(mk(0, 1, 0, 'h700,  'h800,  0, 0, 0, 0, 0, 0, 0,      1, 1, 1));
    vt.push_back(mk(0, 0, 0, 0,      0,      1, 1, 1, 1, 0, 1, 'h800,  0, 0, 1));
    vt.push_back(mk(1, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 0,      0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 0,      0, 1, 0));

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].pv, vt[i].pt, vt[i].pc, vt[i].tgt, vt[i].rv, vt[i].rt);
      chk($sformatf("v%0d_cond", i), upd_cond, vt[i].e_cond);
      chk($sformatf("v%0d_act", i), upd_act_taken, vt[i].e_act);
      chk($sformatf("v%0d_pred", i), upd_pred_taken, vt[i].e_pred);
      chk($sformatf("v%0d_flush", i), flush, vt[i].e_flush);
      if (vt[i].e_flush) chk($sformatf("v%0d_redir", i), redirect_pc, vt[i].e_redir);
      chk($sformatf("v%0d_occ", i), occupancy, vt[i].e_occ);
      chk($sformatf("v%0d_ready", i), pred_ready, vt[i].e_ready);
      chk($sformatf("v%0d_err", i), err_underflow, vt[i].e_err);
    end

    // Saturation of the narrow-counter instance: 20 correct resolutions after reset.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 'h900 + 32'(i * 4), 'hA00, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
    end
    chk("sat_br15", br_cnt_s, 4'd15);
    chk("wide_br20", br_cnt, 16'd20);
    chk("sat_mis0", mis_cnt_s, 4'd0);

    // Random traffic; resolution outcome usually agrees with the oldest prediction.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit rt;
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) rt = mq[0].taken;
      else rt = 1'($urandom_range(0, 1));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
           $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1, rt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
